hd44780_lcd_responder: RTL
==========================

// Module: hd44780_lcd_responder
// PURPOSE
//  Device-side model of a 16x2 HD44780 panel in 8-bit mode. It is the receiving end of the game's LCD bus.
//  It samples rs/rw/e/data from the LCD controller, decodes commands and character writes, and keeps a
//  32-character screen buffer (DDRAM subset). It answers busy-flag and data reads. Used in simulation and as an
//  on-FPGA mirror so the screen contents can be checked or dumped.
// PARAMETERS
//  SYNC_STAGES   2     input synchronizer depth on rs/rw/e/data (>=2)
//  BUSY_CYCLES   50    clk cycles busy after any non-clear op
//  CLEAR_CYCLES  1000  clk cycles busy after Clear Display (min 32)
// PORTS
//  clk              in   1  system clock
//  rst              in   1  asynchronous, active-high reset
//  lcd_rs           in   1  0=instruction, 1=data
//  lcd_rw           in   1  0=write, 1=read
//  lcd_e            in   1  enable; transfer completes on its falling edge
//  lcd_data_in      in   8  bus from controller
//  lcd_data_out     out  8  read-back data
//  lcd_data_oe      out  1  high while responder drives the bus
//  rd_addr          in   5  screen-buffer read index (0-15 line1, 16-31 line2)
//  rd_char          out  8  buffer[rd_addr], registered, 1-cycle latency
//  busy             out  1  busy flag (BF)
//  display_on       out  1  D bit of Display Control
//  cursor_on        out  1  C bit
//  two_line_8bit    out  1  last Function Set had DL=1 and N=1
//  ddram_addr       out  7  address counter (AC)
//  cmd_strobe       out  1  1-cycle pulse per accepted instruction
//  data_strobe      out  1  1-cycle pulse per accepted data write
//  write_while_busy out  1  sticky; set when a write arrives while busy=1
// BEHAVIOUR
//  - All bus inputs pass through SYNC_STAGES flops. Event = synchronized e 1->0. rs/rw/data are taken from
//    the same synchronized sample as e=1 on the cycle before the fall.
//  - Reset values: lcd_data_out=0, lcd_data_oe=0, busy=1, display_on=0, cursor_on=0, two_line_8bit=0,
//    ddram_addr=0, strobes=0, write_while_busy=0, I/D=1. On reset release, FSM enters CLEARING.
//  - FSM states:
//    * IDLE: waits for an event.
//    * EXEC: one cycle; decodes the instruction and pulses the strobe.
//    * CLEARING: writes 0x20 to buffer[0..31], one entry/cycle (32 cycles), then goes to BUSY_WAIT.
//    * BUSY_WAIT: counts down the busy count, then returns to IDLE.
//  - busy=1 in EXEC/CLEARING/BUSY_WAIT. The busy count is loaded at EXEC with BUSY_CYCLES, or with
//    CLEAR_CYCLES-32 on a clear. After reset, CLEARING goes straight to IDLE.
//  - A write event while busy=1 is ignored: no state change, no strobe, write_while_busy<=1. Cleared only by rst.
//  - Instruction decode (highest set bit wins):
//    * 1xxxxxxx: AC<=data[6:0].
//    * 01xxxxxx: CGRAM set; accepted but no effect.
//    * 001DNFxx: two_line_8bit<=D&N.
//    * 00001DCB: display_on<=D, cursor_on<=C.
//    * 000001IS: I/D<=I; S is ignored.
//    * 0000001x: AC<=0; busy for CLEAR_CYCLES.
//    * 00000001: enters CLEARING, AC<=0, I/D<=1.
//    * 0x00: NOP with busy.
//  - Data write (rs=1,rw=0): stores into the buffer only if AC is in 0x00-0x0F (index AC) or 0x40-0x4F
//    (index AC-0x30). Other AC values discard the data. AC then steps in either case.
//  - AC step: with I/D=1, 0x27->0x40, 0x67->0x00, else +1. With I/D=0, 0x00->0x67, 0x40->0x27, else -1.
//  - Reads: while synchronized e=1 and rw=1, lcd_data_oe=1.
//    * rs=0: lcd_data_out={busy,AC}.
//    * rs=1: lcd_data_out=char at AC, or 0x20 if AC is unmapped.
//    * A data read steps AC on e fall and is ignored if busy. A busy-flag read is always allowed and never
//      sets the flag.
//  - rd_char port is independent of bus activity. If rd_addr hits an entry being written in the same cycle,
//    rd_char returns the old value.
//  - rst mid-operation aborts any state: outputs go to reset values and the full 32-cycle CLEAR runs again.
// TESTING
//  1 Init 0x38,0x0C,0x01,0x06, each 1024 clk apart, e high 512 clk -> two_line_8bit=1, display_on=1,
//    all rd_char=0x20, write_while_busy=0.
//  2 0x80 then data 0x41,0x42 -> rd_char[0]=0x41, rd_char[1]=0x42, ddram_addr=0x02, 3 strobes total.
//  3 0xC0 then 17 data bytes -> rd_char[16..31] set; 17th byte discarded; ddram_addr=0x51.
//    Then 0xA7 plus one write -> ddram_addr=0x40.
//  4 0x01, then data 0x55 issued 100 clk later -> write ignored, write_while_busy=1, data_strobe stays 0.
//  5 rs=0,rw=1,e=1 right after 0x01 -> lcd_data_oe=1, lcd_data_out=0x80.
//    After CLEAR_CYCLES -> lcd_data_out=0x00.
//  6 Assert rst mid-CLEARING -> busy=1, ddram_addr=0, display_on=0.
//    32 clk after release -> buffer all 0x20, busy=0.

Source files
------------

// File: rtl/hd44780_lcd_responder_if.sv
// LCD bus between an HD44780-style controller (master) and the panel-side responder (slave).
// The controller drives rs/rw/e/data; the responder answers reads on lcd_data_out/lcd_data_oe.
interface hd44780_lcd_responder_if;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [7:0] lcd_data_in;
  logic [7:0] lcd_data_out;
  logic       lcd_data_oe;

  modport master (
    output lcd_rs,
    output lcd_rw,
    output lcd_e,
    output lcd_data_in,
    input  lcd_data_out,
    input  lcd_data_oe
  );

  modport slave (
    input  lcd_rs,
    input  lcd_rw,
    input  lcd_e,
    input  lcd_data_in,
    output lcd_data_out,
    output lcd_data_oe
  );
endinterface

// File: rtl/hd44780_lcd_responder.sv
// Device-side model of a 16x2 HD44780 panel in 8-bit mode: decodes bus transfers on the falling
// edge of e, keeps a 32-entry screen buffer, and answers busy-flag and data reads.
module hd44780_lcd_responder #(
  parameter int SYNC_STAGES  = 2,
  parameter int BUSY_CYCLES  = 50,
  parameter int CLEAR_CYCLES = 1000
) (
  input  logic                          clk,
  input  logic                          rst,
  hd44780_lcd_responder_if.slave        lcd,
  input  logic [4:0]                    rd_addr,
  output logic [7:0]                    rd_char,
  output logic                          busy,
  output logic                          display_on,
  output logic                          cursor_on,
  output logic                          two_line_8bit,
  output logic [6:0]                    ddram_addr,
  output logic                          cmd_strobe,
  output logic                          data_strobe,
  output logic                          write_while_busy
);

  localparam int MAX_CYCLES = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam int BW         = 11;

  localparam logic [CW-1:0] BUSY_LOAD  = CW'(BUSY_CYCLES);
  localparam logic [CW-1:0] HOME_LOAD  = CW'(CLEAR_CYCLES);
  localparam logic [CW-1:0] CLEAR_LOAD = CW'(CLEAR_CYCLES - 32);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_CLEARING,
    S_BUSY_WAIT
  } state_t;

  // Bus synchronizer; each stage holds {rs, rw, e, data}
  logic [BW-1:0] sync_q [SYNC_STAGES];
  logic [BW-1:0] sync_d [SYNC_STAGES];
  logic [BW-1:0] prev_q;
  logic [BW-1:0] prev_d;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    clr_idx_q, clr_idx_d;
  logic          from_reset_q, from_reset_d;
  logic [6:0]    ac_q, ac_d;
  logic          id_q, id_d;
  logic          display_on_q, display_on_d;
  logic          cursor_on_q, cursor_on_d;
  logic          two_line_q, two_line_d;
  logic          wwb_q, wwb_d;
  logic          cmd_strobe_q, cmd_strobe_d;
  logic          data_strobe_q, data_strobe_d;
  logic          op_rs_q, op_rs_d;
  logic          op_rw_q, op_rw_d;
  logic [7:0]    op_data_q, op_data_d;
  logic [7:0]    rd_char_q, rd_char_d;

  logic [7:0]    screen_q [32];
  logic          scr_we;
  logic [4:0]    scr_waddr;
  logic [7:0]    scr_wdata;

  logic          cur_rs;
  logic          cur_rw;
  logic          cur_e;
  logic          ev_rs;
  logic          ev_rw;
  logic          ev_e;
  logic [7:0]    ev_data;
  logic          bus_event;
  logic          busy_w;
  logic          ac_mapped;
  logic [4:0]    ac_idx;
  logic [6:0]    ac_step;
  logic          rd_oe;
  logic [7:0]    rd_out;

  always_comb begin
    sync_d[0] = {lcd.lcd_rs, lcd.lcd_rw, lcd.lcd_e, lcd.lcd_data_in};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_q <= '0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      prev_q <= prev_d;
    end
  end

  assign cur_rs    = sync_q[SYNC_STAGES-1][10];
  assign cur_rw    = sync_q[SYNC_STAGES-1][9];
  assign cur_e     = sync_q[SYNC_STAGES-1][8];
  assign ev_rs     = prev_q[10];
  assign ev_rw     = prev_q[9];
  assign ev_e      = prev_q[8];
  assign ev_data   = prev_q[7:0];
  assign bus_event = ev_e & ~cur_e;
  assign busy_w    = (state_q != S_IDLE);

  // Only 0x00-0x0F and 0x40-0x4F are visible on a 16x2 panel
  assign ac_mapped = (ac_q[5:4] == 2'b00);
  assign ac_idx    = {ac_q[6], ac_q[3:0]};

  always_comb begin
    ac_step = ac_q;
    if (id_q) begin
      if (ac_q == 7'h27) begin
        ac_step = 7'h40;
      end else if (ac_q == 7'h67) begin
        ac_step = 7'h00;
      end else begin
        ac_step = ac_q + 7'd1;
      end
    end else begin
      if (ac_q == 7'h00) begin
        ac_step = 7'h67;
      end else if (ac_q == 7'h40) begin
        ac_step = 7'h27;
      end else begin
        ac_step = ac_q - 7'd1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    clr_idx_d     = clr_idx_q;
    from_reset_d  = from_reset_q;
    ac_d          = ac_q;
    id_d          = id_q;
    display_on_d  = display_on_q;
    cursor_on_d   = cursor_on_q;
    two_line_d    = two_line_q;
    wwb_d         = wwb_q;
    cmd_strobe_d  = 1'b0;
    data_strobe_d = 1'b0;
    op_rs_d       = op_rs_q;
    op_rw_d       = op_rw_q;
    op_data_d     = op_data_q;
    scr_we        = 1'b0;
    scr_waddr     = clr_idx_q;
    scr_wdata     = 8'h20;

    if (bus_event && busy_w && !ev_rw) begin
      wwb_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        // Busy-flag reads (rs=0, rw=1) never start an operation
        if (bus_event && !(ev_rw && !ev_rs)) begin
          op_rs_d   = ev_rs;
          op_rw_d   = ev_rw;
          op_data_d = ev_data;
          state_d   = S_EXEC;
        end
      end

      S_EXEC: begin
        state_d = S_BUSY_WAIT;
        cnt_d   = BUSY_LOAD;
        if (!op_rs_q) begin
          cmd_strobe_d = 1'b1;
          casez (op_data_q)
            8'b1???????: ac_d = op_data_q[6:0];
            8'b01??????: begin end
            8'b001?????: two_line_d = op_data_q[4] & op_data_q[3];
            8'b0001????: begin end
            8'b00001???: begin
              display_on_d = op_data_q[2];
              cursor_on_d  = op_data_q[1];
            end
            8'b000001??: id_d = op_data_q[1];
            8'b0000001?: begin
              ac_d  = 7'h00;
              cnt_d = HOME_LOAD;
            end
            8'b00000001: begin
              ac_d         = 7'h00;
              id_d         = 1'b1;
              cnt_d        = CLEAR_LOAD;
              clr_idx_d    = 5'd0;
              from_reset_d = 1'b0;
              state_d      = S_CLEARING;
            end
            default: begin end
          endcase
        end else begin
          if (!op_rw_q) begin
            data_strobe_d = 1'b1;
            if (ac_mapped) begin
              scr_we    = 1'b1;
              scr_waddr = ac_idx;
              scr_wdata = op_data_q;
            end
          end
          ac_d = ac_step;
        end
      end

      S_CLEARING: begin
        scr_we    = 1'b1;
        scr_waddr = clr_idx_q;
        scr_wdata = 8'h20;
        clr_idx_d = clr_idx_q + 5'd1;
        if (clr_idx_q == 5'd31) begin
          state_d      = from_reset_q ? S_IDLE : S_BUSY_WAIT;
          from_reset_d = 1'b0;
        end
      end

      S_BUSY_WAIT: begin
        if (cnt_q <= CNT_ONE) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Reset lands in CLEARING so the buffer is blanked after every reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_CLEARING;
      cnt_q         <= '0;
      clr_idx_q     <= 5'd0;
      from_reset_q  <= 1'b1;
      ac_q          <= 7'h00;
      id_q          <= 1'b1;
      display_on_q  <= 1'b0;
      cursor_on_q   <= 1'b0;
      two_line_q    <= 1'b0;
      wwb_q         <= 1'b0;
      cmd_strobe_q  <= 1'b0;
      data_strobe_q <= 1'b0;
      op_rs_q       <= 1'b0;
      op_rw_q       <= 1'b0;
      op_data_q     <= 8'h00;
      rd_char_q     <= 8'h00;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      clr_idx_q     <= clr_idx_d;
      from_reset_q  <= from_reset_d;
      ac_q          <= ac_d;
      id_q          <= id_d;
      display_on_q  <= display_on_d;
      cursor_on_q   <= cursor_on_d;
      two_line_q    <= two_line_d;
      wwb_q         <= wwb_d;
      cmd_strobe_q  <= cmd_strobe_d;
      data_strobe_q <= data_strobe_d;
      op_rs_q       <= op_rs_d;
      op_rw_q       <= op_rw_d;
      op_data_q     <= op_data_d;
      rd_char_q     <= rd_char_d;
    end
  end

  always_ff @(posedge clk) begin
    if (scr_we) begin
      screen_q[scr_waddr] <= scr_wdata;
    end
  end

  // rd_char samples the pre-write contents when a write hits the same entry
  always_comb begin
    rd_char_d = screen_q[rd_addr];
  end

  always_comb begin
    rd_oe  = cur_e & cur_rw;
    rd_out = 8'h00;
    if (rd_oe) begin
      if (cur_rs) begin
        rd_out = ac_mapped ? screen_q[ac_idx] : 8'h20;
      end else begin
        rd_out = {busy_w, ac_q};
      end
    end
  end

  assign lcd.lcd_data_out = rd_out;
  assign lcd.lcd_data_oe  = rd_oe;
  assign rd_char          = rd_char_q;
  assign busy             = busy_w;
  assign display_on       = display_on_q;
  assign cursor_on        = cursor_on_q;
  assign two_line_8bit    = two_line_q;
  assign ddram_addr       = ac_q;
  assign cmd_strobe       = cmd_strobe_q;
  assign data_strobe      = data_strobe_q;
  assign write_while_busy = wwb_q;

endmodule
